fetch_buf_stage: RTL and testbench

- Parametrised N-wide fetch stage with an internal fetch queue (FQ) between the icache and dispatch.
- Holds the fetch PC and requests FETCH_WIDTH sequential words from the icache each cycle.
- Enqueues the leading contiguous valid words into a circular buffer, up to the free space available.
- Presents up to DISP_WIDTH oldest packets to dispatch. A redirect (mispredict/recovery) flushes the queue and restarts fetch.

---
 rtl/sys_defs.sv | 26 ++
 rtl/fetch_queue.sv | 109 ++++++++++
 rtl/fetch_buf_stage.sv | 128 ++++++++++++
 tb/tb_fetch_buf_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the fetch front end: XLEN, default widths and the
// fetch-to-decode packet carried through the fetch queue.
package sys_defs;

    localparam int SYS_XLEN        = 32;
    localparam int FETCH_WIDTH_DEF = 3;
    localparam int DISP_WIDTH_DEF  = 3;
    localparam int FQ_DEPTH_DEF    = 8;
    localparam int FQ_IDX_W        = $clog2(FQ_DEPTH_DEF);
    localparam int FQ_CNT_W        = $clog2(FQ_DEPTH_DEF + 1);

    // One fetched instruction as handed from fetch to decode/dispatch.
    typedef struct packed {
        logic                valid;
        logic [31:0]         inst;
        logic [SYS_XLEN-1:0] pc;
        logic [SYS_XLEN-1:0] npc;
    } IF_ID_PACKET;

    // Address of the word 'slot' positions after 'base' in program order.
    function automatic logic [SYS_XLEN-1:0] word_addr(input logic [SYS_XLEN-1:0] base,
                                                      input int unsigned         slot);
        return base + SYS_XLEN'(slot << 2);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Multi-push / multi-pop circular fetch queue with single-cycle flush.
// push_pkts[0] is the oldest word being written; out_pkts[DISP_WIDTH-1] is
// the oldest entry held. Also contains fetch_queue_chk, the protocol checker
// for the dispatch side.
module fetch_queue
    import sys_defs::*;
#(
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int DISP_WIDTH  = DISP_WIDTH_DEF,
    parameter int FQ_DEPTH    = FQ_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [$clog2(FQ_DEPTH+1)-1:0]      push_cnt,
    input  IF_ID_PACKET [FETCH_WIDTH-1:0]      push_pkts,
    input  logic [$clog2(DISP_WIDTH+1)-1:0]    pop_cnt,
    output IF_ID_PACKET [DISP_WIDTH-1:0]       out_pkts,
    output logic [$clog2(FQ_DEPTH+1)-1:0]      count,
    output logic                               full
);

    localparam int IDX_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    IF_ID_PACKET         mem_r [FQ_DEPTH];
    logic [IDX_W-1:0]    head_r;
    logic [IDX_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;
    logic                full_r;
    logic [CNT_W-1:0]    count_s;

    assign count = count_r;
    assign full  = full_r;

    // Occupancy after this cycle's pushes and pops.
    always_comb begin
        count_s = count_r + push_cnt - CNT_W'(pop_cnt);
    end

    // Head/tail/occupancy registers; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
        end else begin
            head_r  <= head_r + IDX_W'(pop_cnt);
            tail_r  <= tail_r + IDX_W'(push_cnt);
            count_r <= count_s;
            full_r  <= (count_s == CNT_W'(FQ_DEPTH));
        end
    end

    // Entry storage: write the accepted words at tail in program order.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (CNT_W'(i) < push_cnt) begin
                    mem_r[tail_r + IDX_W'(i)] <= push_pkts[i];
                end
            end
        end
    end

    // Present the oldest occupied entries, invalid beyond the occupancy.
    always_comb begin
        out_pkts = '0;
        for (int j = 0; j < DISP_WIDTH; j++) begin
            if (CNT_W'(j) < count_r) begin
                out_pkts[DISP_WIDTH-1-j] = mem_r[head_r + IDX_W'(j)];
            end else begin
                out_pkts[DISP_WIDTH-1-j] = '0;
            end
        end
    end

    fetch_queue_chk #(
        .DISP_WIDTH (DISP_WIDTH),
        .FQ_DEPTH   (FQ_DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .pop_cnt (pop_cnt),
        .count   (count_r)
    );

endmodule

// Dispatch may never consume more packets than are presented as valid.
module fetch_queue_chk #(
    parameter int DISP_WIDTH = 3,
    parameter int FQ_DEPTH   = 8
) (
    input logic                            clk,
    input logic                            rst,
    input logic [$clog2(DISP_WIDTH+1)-1:0] pop_cnt,
    input logic [$clog2(FQ_DEPTH+1)-1:0]   count
);

    localparam int CNT_W  = $clog2(FQ_DEPTH + 1);
    localparam int TAKE_W = $clog2(DISP_WIDTH + 1);

    // Pop count bounded by both the dispatch width and the occupancy.
    a_take_legal: assert property (@(posedge clk) disable iff (rst)
        (pop_cnt <= TAKE_W'(DISP_WIDTH)) && (CNT_W'(pop_cnt) <= count));

endmodule

// File: rtl/fetch_buf_stage.sv
// N-wide fetch stage: owns the fetch PC, issues sequential icache requests,
// accepts the leading run of valid words that fits in the fetch queue and
// hands the oldest queued packets to dispatch. Redirect flushes and restarts.
// Optional branch-prediction steering is enabled by defining FETCH_BP_EN.
module fetch_buf_stage
    import sys_defs::*;
#(
    parameter int                  FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int                  DISP_WIDTH  = DISP_WIDTH_DEF,
    parameter int                  FQ_DEPTH    = FQ_DEPTH_DEF,
    parameter logic [SYS_XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   redirect_valid,
    input  logic [SYS_XLEN-1:0]                    redirect_pc,
    output logic [FETCH_WIDTH-1:0][SYS_XLEN-1:0]   icache_req_addr,
    input  logic [FETCH_WIDTH-1:0][31:0]           icache_data,
    input  logic [FETCH_WIDTH-1:0]                 icache_valid,
`ifdef FETCH_BP_EN
    input  logic [FETCH_WIDTH-1:0]                 bp_taken,
    input  logic [FETCH_WIDTH-1:0][SYS_XLEN-1:0]   bp_target,
    output logic [FETCH_WIDTH-1:0][SYS_XLEN-1:0]   bp_fetch_addr,
`endif
    output IF_ID_PACKET [DISP_WIDTH-1:0]           fq_pkts,
    input  logic [$clog2(DISP_WIDTH+1)-1:0]        disp_take,
    output logic [$clog2(FQ_DEPTH+1)-1:0]          fq_count,
    output logic                                   fq_full
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    logic [SYS_XLEN-1:0]              fetch_pc_r;
    logic [SYS_XLEN-1:0]              next_pc_s;
    logic [CNT_W-1:0]                 avail_s;
    logic [CNT_W-1:0]                 free_s;
    logic [CNT_W-1:0]                 push_s;
    logic                             run_s;
    IF_ID_PACKET [FETCH_WIDTH-1:0]    push_pkts_s;
`ifdef FETCH_BP_EN
    logic                             taken_hit_s;
`endif

    // Sequential request addresses; the highest lane carries fetch_pc.
    always_comb begin
        icache_req_addr = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            icache_req_addr[k] = word_addr(fetch_pc_r, (FETCH_WIDTH - 1 - k));
        end
    end

`ifdef FETCH_BP_EN
    assign bp_fetch_addr = icache_req_addr;
`endif

    // Acceptance: contiguous valid prefix clamped to free space, then
    // optional truncation at the first predicted-taken accepted word.
    always_comb begin
        avail_s     = '0;
        run_s       = 1'b1;
        push_pkts_s = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (run_s && icache_valid[FETCH_WIDTH-1-i]) begin
                avail_s = avail_s + CNT_W'(1);
            end else begin
                run_s = 1'b0;
            end
        end

        free_s = CNT_W'(FQ_DEPTH) - fq_count;
        if (avail_s < free_s) begin
            push_s = avail_s;
        end else begin
            push_s = free_s;
        end

        for (int i = 0; i < FETCH_WIDTH; i++) begin
            push_pkts_s[i].valid = 1'b1;
            push_pkts_s[i].inst  = icache_data[FETCH_WIDTH-1-i];
            push_pkts_s[i].pc    = word_addr(fetch_pc_r, i);
            push_pkts_s[i].npc   = word_addr(fetch_pc_r, i + 1);
        end

        next_pc_s = fetch_pc_r + (SYS_XLEN'(push_s) << 2);

`ifdef FETCH_BP_EN
        taken_hit_s = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!taken_hit_s && (CNT_W'(i) < push_s) && bp_taken[FETCH_WIDTH-1-i]) begin
                taken_hit_s        = 1'b1;
                push_s             = CNT_W'(i + 1);
                push_pkts_s[i].npc = bp_target[FETCH_WIDTH-1-i];
                next_pc_s          = bp_target[FETCH_WIDTH-1-i];
            end else begin
                taken_hit_s = taken_hit_s;
            end
        end
`endif
    end

    // Fetch PC: redirect wins over normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
        end else begin
            fetch_pc_r <= next_pc_s;
        end
    end

    fetch_queue #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .DISP_WIDTH  (DISP_WIDTH),
        .FQ_DEPTH    (FQ_DEPTH)
    ) u_fq (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push_cnt  (push_s),
        .push_pkts (push_pkts_s),
        .pop_cnt   (disp_take),
        .out_pkts  (fq_pkts),
        .count     (fq_count),
        .full      (fq_full)
    );

endmodule

// File: tb/tb_fetch_buf_stage.sv
// Scoreboard bench for fetch_buf_stage. The stimulus process drives the
// icache/dispatch/redirect inputs and predicts which words the queue should
// accept; the monitor compares the visible queue state every cycle.
module tb_fetch_buf_stage;
    import sys_defs::*;

    localparam int FW    = 3;
    localparam int DW    = 3;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic [FW-1:0][31:0]        icache_req_addr;
    logic [FW-1:0][31:0]        icache_data;
    logic [FW-1:0]              icache_valid;
`ifdef FETCH_BP_EN
    logic [FW-1:0]              bp_taken;
    logic [FW-1:0][31:0]        bp_target;
    logic [FW-1:0][31:0]        bp_fetch_addr;
`endif
    IF_ID_PACKET [DW-1:0]       fq_pkts;
    logic [1:0]                 disp_take;
    logic [3:0]                 fq_count;
    logic                       fq_full;

    exp_t        exp_q[$];
    exp_t        pend_q[$];
    logic [31:0] cur_pc = 32'h0;
    logic [31:0] nxt_pc = 32'h0;
    logic        started = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_buf_stage #(
        .FETCH_WIDTH (FW),
        .DISP_WIDTH  (DW),
        .FQ_DEPTH    (DEPTH),
        .RESET_PC    (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .icache_req_addr (icache_req_addr),
        .icache_data     (icache_data),
        .icache_valid    (icache_valid),
`ifdef FETCH_BP_EN
        .bp_taken        (bp_taken),
        .bp_target       (bp_target),
        .bp_fetch_addr   (bp_fetch_addr),
`endif
        .fq_pkts         (fq_pkts),
        .disp_take       (disp_take),
        .fq_count        (fq_count),
        .fq_full         (fq_full)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the predicted set of accepted words.
    task automatic drive_cycle(input logic [FW-1:0] v, input int take_req,
                               input logic redir, input logic [31:0] rpc,
                               input logic do_rst);
        int          take;
        int          avail;
        int          free;
        int          push;
        int          hit;
        bit          run;
        logic [31:0] tgt;
        exp_t        e;

        take = take_req;
        if (take > exp_q.size()) take = exp_q.size();
        if (take > DW) take = DW;

        rst            = do_rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        icache_valid   = v;
        disp_take      = 2'(take);
        for (int k = 0; k < FW; k++) icache_data[k] = $urandom();
`ifdef FETCH_BP_EN
        for (int k = 0; k < FW; k++) begin
            bp_taken[k]  = ($urandom_range(0, 3) == 0);
            bp_target[k] = $urandom() & 32'hFFFF_FFFC;
        end
`endif
        pend_q.delete();
        hit = -1;
        tgt = 32'h0;

        if (do_rst) begin
            nxt_pc = 32'h0;
        end else if (redir) begin
            nxt_pc = rpc;
        end else begin
            avail = 0;
            run   = 1'b1;
            for (int i = 0; i < FW; i++) begin
                if (run && v[FW-1-i]) avail++;
                else run = 1'b0;
            end
            free = DEPTH - exp_q.size();
            push = (avail < free) ? avail : free;
`ifdef FETCH_BP_EN
            for (int i = 0; i < push; i++) begin
                if (hit < 0 && bp_taken[FW-1-i]) hit = i;
            end
            if (hit >= 0) begin
                push = hit + 1;
                tgt  = bp_target[FW-1-hit];
            end
`endif
            for (int i = 0; i < push; i++) begin
                e.pc   = cur_pc + 32'(4 * i);
                e.npc  = (i == hit) ? tgt : e.pc + 32'd4;
                e.inst = icache_data[FW-1-i];
                pend_q.push_back(e);
            end
            nxt_pc = (hit >= 0) ? tgt : cur_pc + 32'(4 * push);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare visible state mid-cycle, then retire this cycle's effects.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check32("fq_count", 32'(fq_count), 32'(exp_q.size()));
                check32("fq_full", 32'(fq_full), (exp_q.size() == DEPTH) ? 32'd1 : 32'd0);
                for (int k = 0; k < FW; k++) begin
                    check32($sformatf("req_addr[%0d]", k), icache_req_addr[k],
                            cur_pc + 32'(4 * (FW - 1 - k)));
`ifdef FETCH_BP_EN
                    check32($sformatf("bp_fetch_addr[%0d]", k), bp_fetch_addr[k],
                            cur_pc + 32'(4 * (FW - 1 - k)));
`endif
                end
                for (int j = 0; j < DW; j++) begin
                    if (j < exp_q.size()) begin
                        check32($sformatf("pkt%0d.valid", j), 32'(fq_pkts[DW-1-j].valid), 32'd1);
                        check32($sformatf("pkt%0d.pc", j), fq_pkts[DW-1-j].pc, exp_q[j].pc);
                        check32($sformatf("pkt%0d.npc", j), fq_pkts[DW-1-j].npc, exp_q[j].npc);
                        check32($sformatf("pkt%0d.inst", j), fq_pkts[DW-1-j].inst, exp_q[j].inst);
                    end else begin
                        check32($sformatf("pkt%0d.valid", j), 32'(fq_pkts[DW-1-j].valid), 32'd0);
                        check32($sformatf("pkt%0d.inst", j), fq_pkts[DW-1-j].inst, 32'd0);
                    end
                end
                if (rst || redirect_valid) begin
                    exp_q.delete();
                end else begin
                    for (int t = 0; t < int'(disp_take); t++) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                end
                pend_q.delete();
                cur_pc = nxt_pc;
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        icache_valid   = '0;
        icache_data    = '0;
        disp_take      = 2'd0;
`ifdef FETCH_BP_EN
        bp_taken       = '0;
        bp_target      = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;

        // Fill from reset with no dispatch: 3, 3, 2, then full and holding.
        repeat (5) drive_cycle(3'b111, 0, 1'b0, 32'h0, 1'b0);
        // Redirect while full with a concurrent take.
        drive_cycle(3'b111, 2, 1'b1, 32'h0000_0400, 1'b0);
        // Hole in lane 1: only the first word is accepted.
        drive_cycle(3'b101, 0, 1'b0, 32'h0, 1'b0);
        // Steady streaming, pointers wrap several times.
        repeat (12) drive_cycle(3'b111, 3, 1'b0, 32'h0, 1'b0);
        drive_cycle(3'b111, 1, 1'b0, 32'h0, 1'b0);
        // Reset with entries held.
        drive_cycle(3'b111, 0, 1'b0, 32'h0, 1'b1);
        // Redirect while empty, near the top of the address space.
        drive_cycle(3'b000, 0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (3) drive_cycle(3'b111, 0, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [FW-1:0] v;
            logic [31:0]   rpc;
            v   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            rpc = $urandom() & 32'hFFFF_FFFC;
            drive_cycle(v, int'($urandom_range(0, 3)),
                        ($urandom_range(0, 19) == 0), rpc,
                        ($urandom_range(0, 79) == 0));
        end

        drive_cycle(3'b000, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
